keyboard_decoder: RTL and testbench

KEYBOARD_DECODER -- requirements
Module: keyboard_decoder

---
 rtl/keyboard_pkg.sv | 81 ++++++++
 rtl/ps2_receiver.sv | 137 +++++++++++++
 rtl/keyboard_decoder.sv | 87 ++++++++
 tb/tb_keyboard_decoder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keyboard_pkg.sv
// Shared constants, receiver state type and the PS/2 set-2 scan-code to ASCII table
// for the keyboard decoder.
package keyboard_pkg;

    localparam logic [7:0] SYM_LEFT      = 8'd1;
    localparam logic [7:0] SYM_RIGHT     = 8'd2;
    localparam logic [7:0] SYM_BACKSPACE = 8'd3;

    localparam logic [7:0] PREFIX_EXT    = 8'hE0;
    localparam logic [7:0] PREFIX_BRK    = 8'hF0;

    localparam logic [7:0] SC_LSHIFT     = 8'h12;
    localparam logic [7:0] SC_RSHIFT     = 8'h59;
    localparam logic [7:0] SC_LEFT       = 8'h6B;
    localparam logic [7:0] SC_RIGHT      = 8'h74;
    localparam logic [7:0] SC_BACKSPACE  = 8'h66;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // Only glyphs of the calculator alphabet are produced; letters ignore shift,
    // and shifted keys whose glyph is outside that alphabet return 0 (no key).
    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic shift);
        logic [7:0] ch;
        ch = 8'h00;
        case (code)
            8'h1C: ch = "a";
            8'h32: ch = "b";
            8'h21: ch = "c";
            8'h23: ch = "d";
            8'h24: ch = "e";
            8'h2B: ch = "f";
            8'h34: ch = "g";
            8'h33: ch = "h";
            8'h43: ch = "i";
            8'h3B: ch = "j";
            8'h42: ch = "k";
            8'h4B: ch = "l";
            8'h3A: ch = "m";
            8'h31: ch = "n";
            8'h44: ch = "o";
            8'h4D: ch = "p";
            8'h15: ch = "q";
            8'h2D: ch = "r";
            8'h1B: ch = "s";
            8'h2C: ch = "t";
            8'h3C: ch = "u";
            8'h2A: ch = "v";
            8'h1D: ch = "w";
            8'h22: ch = "x";
            8'h35: ch = "y";
            8'h1A: ch = "z";
            8'h45: ch = shift ? ")" : "0";
            8'h16: ch = shift ? 8'h00 : "1";
            8'h1E: ch = shift ? 8'h00 : "2";
            8'h26: ch = shift ? 8'h00 : "3";
            8'h25: ch = shift ? 8'h00 : "4";
            8'h2E: ch = shift ? 8'h00 : "5";
            8'h36: ch = shift ? "^" : "6";
            8'h3D: ch = shift ? 8'h00 : "7";
            8'h3E: ch = shift ? "*" : "8";
            8'h46: ch = shift ? "(" : "9";
            8'h29: ch = " ";
            8'h4E: ch = shift ? 8'h00 : "-";
            8'h55: ch = shift ? "+" : 8'h00;
            8'h4A: ch = shift ? 8'h00 : "/";
            8'h49: ch = shift ? 8'h00 : ".";
            8'h79: ch = "+";
            8'h7B: ch = "-";
            8'h7C: ch = "*";
            8'h71: ch = ".";
            default: ch = 8'h00;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver: synchronizes and deglitches the lines,
// assembles 11-bit frames and emits checked bytes.
module ps2_receiver
    import keyboard_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_s;
    logic          data_s;

    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          filt_commit;
    logic          fall;

    rx_state_t     state;
    rx_state_t     state_next;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          parity_bit;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic          frame_ok;

    // Both lines idle high, so the synchronizers reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];

    // filt_cnt counts consecutive cycles the synchronized clock differs from the
    // filtered level; any agreement restarts the count.
    assign filt_commit = (clk_s != filt_clk) && (filt_cnt == FW'(FILTER_LEN - 1));
    assign fall        = filt_commit && filt_clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_commit) begin
            filt_clk <= clk_s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign timeout = (state != RX_IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == RX_IDLE || fall) begin
            to_cnt <= '0;
        end else if (to_cnt != TW'(TIMEOUT_CYCLES)) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (timeout) begin
            state_next = RX_IDLE;
        end else if (fall) begin
            case (state)
                RX_IDLE:   if (!data_s) state_next = RX_DATA;
                RX_DATA:   if (bit_cnt == 3'd7) state_next = RX_PARITY;
                RX_PARITY: state_next = RX_STOP;
                RX_STOP:   state_next = RX_IDLE;
                default:   state_next = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        frame_ok = (state == RX_STOP) && fall && data_s && (^{shreg, parity_bit});
    end

    // Data bits arrive LSB first, so shift in from the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
        end else if (state == RX_IDLE) begin
            bit_cnt <= '0;
        end else if (fall && state == RX_DATA) begin
            shreg   <= {data_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
        end else if (fall && state == RX_PARITY) begin
            parity_bit <= data_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_valid <= 1'b0;
            byte_data  <= '0;
        end else begin
            byte_valid <= frame_ok;
            if (frame_ok) byte_data <= shreg;
        end
    end

endmodule

// File: rtl/keyboard_decoder.sv
// PS/2 keyboard front end: turns received scan-code bytes into one-cycle symbol
// pulses (arrows, backspace and the calculator character set).
module keyboard_decoder
    import keyboard_pkg::*;
#(
    parameter int SYMBOL_WIDTH   = 7,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ps2_clk,
    input  logic                    ps2_data,
    output logic [SYMBOL_WIDTH-1:0] keyboard_symbol
);

    logic       byte_valid;
    logic [7:0] byte_data;

    logic       ext;
    logic       brk;
    logic       shift;
    logic       ext_next;
    logic       brk_next;
    logic       shift_next;
    logic [7:0] sym_next;
    logic       is_shift_key;

    ps2_receiver #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .byte_data  (byte_data)
    );

    assign is_shift_key = (byte_data == SC_LSHIFT) || (byte_data == SC_RSHIFT);

    // Prefix bytes only arm flags; the next non-prefix byte consumes and clears them.
    always_comb begin
        sym_next   = 8'h00;
        ext_next   = ext;
        brk_next   = brk;
        shift_next = shift;
        if (byte_valid) begin
            if (byte_data == PREFIX_EXT) begin
                ext_next = 1'b1;
            end else if (byte_data == PREFIX_BRK) begin
                brk_next = 1'b1;
            end else begin
                ext_next = 1'b0;
                brk_next = 1'b0;
                if (brk) begin
                    if (is_shift_key) shift_next = 1'b0;
                end else if (ext) begin
                    if (byte_data == SC_LEFT)       sym_next = SYM_LEFT;
                    else if (byte_data == SC_RIGHT) sym_next = SYM_RIGHT;
                end else if (is_shift_key) begin
                    shift_next = 1'b1;
                end else if (byte_data == SC_BACKSPACE) begin
                    sym_next = SYM_BACKSPACE;
                end else begin
                    sym_next = scan_to_ascii(byte_data, shift);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext             <= 1'b0;
            brk             <= 1'b0;
            shift           <= 1'b0;
            keyboard_symbol <= '0;
        end else begin
            ext             <= ext_next;
            brk             <= brk_next;
            shift           <= shift_next;
            keyboard_symbol <= SYMBOL_WIDTH'(sym_next);
        end
    end

endmodule

// File: tb/tb_keyboard_decoder.sv
// Bench for keyboard_decoder: drives PS/2 frames, predicts symbol pulses from a
// table-driven key model and checks the output on every cycle.
module tb_keyboard_decoder;

    localparam int W          = 7;
    localparam int FLEN       = 8;
    localparam int TOUT       = 1000;
    // Stop-bit clock drive to visible symbol: two synchronizer edges, FILTER_LEN
    // stable cycles committing on the next edge, then byte_valid and symbol registers.
    localparam int LAT        = FLEN + 3;

    logic         clk;
    logic         rst_n;
    logic         ps2_clk;
    logic         ps2_data;
    logic [W-1:0] keyboard_symbol;

    int n_cmp;
    int n_err;
    int cyc;

    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    logic [W-1:0] seen_q[$];
    logic [W-1:0] want_q[$];

    logic [7:0] unsh_map[logic [7:0]];
    logic [7:0] shf_map[logic [7:0]];
    logic       m_ext, m_brk, m_shift;

    keyboard_decoder #(
        .SYMBOL_WIDTH   (W),
        .FILTER_LEN     (FLEN),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ps2_clk         (ps2_clk),
        .ps2_data        (ps2_data),
        .keyboard_symbol (keyboard_symbol)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3ms;
        $display("FAIL watchdog: got no end of stimulus, want finish before 3ms");
        $fatal(1, "watchdog expired");
    end

    // ---------------- model ----------------
    task automatic build_tables();
        logic [7:0] letters[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};
        logic [7:0] digits[10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                    8'h3E, 8'h46};
        for (int i = 0; i < 26; i++) begin
            unsh_map[letters[i]] = 8'h61 + 8'(i);
            shf_map[letters[i]]  = 8'h61 + 8'(i);
        end
        for (int i = 0; i < 10; i++) unsh_map[digits[i]] = 8'h30 + 8'(i);
        shf_map[8'h46] = "(";
        shf_map[8'h45] = ")";
        shf_map[8'h3E] = "*";
        shf_map[8'h36] = "^";
        shf_map[8'h55] = "+";
        unsh_map[8'h29] = " ";  shf_map[8'h29] = " ";
        unsh_map[8'h4E] = "-";
        unsh_map[8'h4A] = "/";
        unsh_map[8'h49] = ".";
        unsh_map[8'h79] = "+";  shf_map[8'h79] = "+";
        unsh_map[8'h7B] = "-";  shf_map[8'h7B] = "-";
        unsh_map[8'h7C] = "*";  shf_map[8'h7C] = "*";
        unsh_map[8'h71] = ".";  shf_map[8'h71] = ".";
    endtask

    function automatic logic [7:0] model_byte(input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        if (b == 8'hE0) begin
            m_ext = 1'b1;
            return 8'h00;
        end
        if (b == 8'hF0) begin
            m_brk = 1'b1;
            return 8'h00;
        end
        if (m_brk) begin
            if (b == 8'h12 || b == 8'h59) m_shift = 1'b0;
        end else if (m_ext) begin
            r = (b == 8'h6B) ? 8'd1 : (b == 8'h74) ? 8'd2 : 8'd0;
        end else if (b == 8'h12 || b == 8'h59) begin
            m_shift = 1'b1;
        end else if (b == 8'h66) begin
            r = 8'd3;
        end else if (m_shift) begin
            r = shf_map.exists(b) ? shf_map[b] : 8'h00;
        end else begin
            r = unsh_map.exists(b) ? unsh_map[b] : 8'h00;
        end
        m_ext = 1'b0;
        m_brk = 1'b0;
        return r;
    endfunction

    // ---------------- drivers ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v, input bit is_stop, input logic [7:0] sym);
        ps2_data = v;
        wait_clk(10);
        if (is_stop && sym != 8'h00) begin
            exp_q.push_back(sym[W-1:0]);
            exp_cyc_q.push_back(cyc + LAT);
        end
        ps2_clk = 1'b0;
        wait_clk(20);
        ps2_clk = 1'b1;
        wait_clk(10);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_parity);
        logic [10:0] f;
        logic [7:0]  sym;
        f   = {1'b1, (~^b) ^ bad_parity, b, 1'b0};
        sym = bad_parity ? 8'h00 : model_byte(b);
        for (int i = 0; i < 11; i++) drive_bit(f[i], i == 10, sym);
        ps2_data = 1'b1;
        wait_clk(20);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        logic [10:0] f;
        f = {1'b1, ~^b, b, 1'b0};
        for (int i = 0; i < nbits; i++) drive_bit(f[i], 1'b0, 8'h00);
        ps2_data = 1'b1;
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_shift = 1'b0;
        wait_clk(n);
        rst_n = 1'b1;
        wait_clk(5);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] exp;
        exp = '0;
        if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
            exp = exp_q.pop_front();
            void'(exp_cyc_q.pop_front());
        end
        n_cmp++;
        if (keyboard_symbol !== exp) begin
            n_err++;
            $display("FAIL symbol cycle %0d: got %h want %h", cyc, keyboard_symbol, exp);
        end
        if (keyboard_symbol != '0) seen_q.push_back(keyboard_symbol);
    end

    task automatic check_seen(input string name);
        n_cmp++;
        if (seen_q.size() != want_q.size()) begin
            n_err++;
            $display("FAIL %s count: got %0d pulses want %0d", name, seen_q.size(), want_q.size());
        end else begin
            for (int i = 0; i < want_q.size(); i++) begin
                n_cmp++;
                if (seen_q[i] !== want_q[i]) begin
                    n_err++;
                    $display("FAIL %s pulse %0d: got %h want %h", name, i, seen_q[i], want_q[i]);
                end
            end
        end
        seen_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_shift = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        rst_n = 1'b0;
        build_tables();
        wait_clk(4);
        n_cmp++;
        if (keyboard_symbol !== '0) begin
            n_err++;
            $display("FAIL reset_symbol: got %h want 00", keyboard_symbol);
        end
        rst_n = 1'b1;
        wait_clk(10);

        send_frame(8'h16, 1'b0);
        want_q = '{7'h31};
        check_seen("make_16");

        send_frame(8'hF0, 1'b0); send_frame(8'h16, 1'b0);
        want_q = '{};
        check_seen("break_16");

        send_frame(8'hE0, 1'b0); send_frame(8'h6B, 1'b0);
        send_frame(8'hE0, 1'b0); send_frame(8'h74, 1'b0);
        send_frame(8'h66, 1'b0);
        send_frame(8'hE0, 1'b0); send_frame(8'hF0, 1'b0); send_frame(8'h6B, 1'b0);
        want_q = '{7'h01, 7'h02, 7'h03};
        check_seen("arrows_bksp");

        send_frame(8'h12, 1'b0); send_frame(8'h46, 1'b0);
        send_frame(8'hF0, 1'b0); send_frame(8'h12, 1'b0); send_frame(8'h46, 1'b0);
        want_q = '{7'h28, 7'h39};
        check_seen("shift_9");

        send_frame(8'h1C, 1'b1); send_frame(8'h1C, 1'b0);
        want_q = '{7'h61};
        check_seen("bad_parity");

        send_partial(8'h33, 4);
        wait_clk(TOUT + 10);
        send_frame(8'h45, 1'b0);
        want_q = '{7'h30};
        check_seen("timeout");

        send_partial(8'h24, 5);
        wait_clk(3);
        apply_reset(4);
        send_frame(8'h1C, 1'b0);
        want_q = '{7'h61};
        check_seen("reset_mid");

        send_frame(8'h59, 1'b0); send_frame(8'h55, 1'b0);
        send_frame(8'hF0, 1'b0); send_frame(8'h59, 1'b0); send_frame(8'h55, 1'b0);
        send_frame(8'h22, 1'b0); send_frame(8'h7C, 1'b0); send_frame(8'h05, 1'b0);
        send_frame(8'hE0, 1'b0); send_frame(8'h4A, 1'b0);
        send_frame(8'h1C, 1'b0); send_frame(8'h1C, 1'b0);
        send_frame(8'h59, 1'b0); send_frame(8'h36, 1'b0);
        send_frame(8'hF0, 1'b0); send_frame(8'h59, 1'b0); send_frame(8'h4A, 1'b0);
        want_q = '{7'h2B, 7'h78, 7'h2A, 7'h61, 7'h61, 7'h5E, 7'h2F};
        check_seen("misc_keys");

        wait_clk(40);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_expected: got %0d undelivered want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
